// File: rtl/pipe_add_sub.sv
// pipe_add_sub: pipelined N-bit add/sub with K-bit carry chunks, valid/ready handshake, optional ADD_SUB_SAT_EN saturation
module pipe_add_sub #(
  parameter int N = 16,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [N-1:0] sum,
  output logic         co,
  output logic         ovf
);
  localparam int L = N / K;
  logic [N-1:0] ra [L];
  logic [N-1:0] rb [L];
  logic [N-1:0] rs [L];
  logic [L-1:0] rv, rc;
  logic         rovf;
  logic [N-1:0] pa [L];
  logic [N-1:0] pb [L];
  logic [N-1:0] ps [L];
  logic [N-1:0] ns [L];
  logic [K:0]   cs [L];
  logic [L-1:0] pv, pc, nc;
  logic         nov, adv;
  assign adv     = !(rv[L-1] && !out_rdy);
  assign in_rdy  = adv;
  assign out_vld = rv[L-1];
  assign sum     = rs[L-1];
  assign co      = rc[L-1];
  assign ovf     = rovf;
  // stage i sums chunk i; operands ride along as skew registers
  always_comb begin
    pa[0] = a;
    pb[0] = sub ? ~b : b;
    ps[0] = '0;
    pv[0] = in_vld;
    pc[0] = sub;
    for (int i = 1; i < L; i++) begin
      pa[i] = ra[i-1];
      pb[i] = rb[i-1];
      ps[i] = rs[i-1];
      pv[i] = rv[i-1];
      pc[i] = rc[i-1];
    end
    for (int i = 0; i < L; i++) begin
      cs[i] = {1'b0, pa[i][i*K +: K]} + {1'b0, pb[i][i*K +: K]} + {{K{1'b0}}, pc[i]};
      ns[i] = ps[i];
      ns[i][i*K +: K] = cs[i][K-1:0];
      nc[i] = cs[i][K];
    end
    nov = (pa[L-1][N-1] == pb[L-1][N-1]) && (ns[L-1][N-1] != pa[L-1][N-1]);
`ifdef ADD_SUB_SAT_EN
    if (nov) ns[L-1] = pa[L-1][N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < L; i++) begin
        ra[i] <= '0;
        rb[i] <= '0;
        rs[i] <= '0;
      end
      rv   <= '0;
      rc   <= '0;
      rovf <= 1'b0;
    end else if (adv) begin
      for (int i = 0; i < L; i++) begin
        ra[i] <= pa[i];
        rb[i] <= pb[i];
        rs[i] <= ns[i];
      end
      rv   <= pv;
      rc   <= nc;
      rovf <= nov;
    end
  end
endmodule
